network_rx: RTL

- Tile-side responder for incoming remote requests. Sits between the manycore endpoint's incoming request port and the tile's local resources: DMEM, icache fill port, and tile CSRs.
- Decodes the EPA word address, performs the access, and produces exactly one response per accepted request, one cycle after acceptance.
- Fully pipelined: one request per cycle.

---
 rtl/network_rx_pkg.sv | 36 +++
 rtl/network_rx_load_packer.sv | 30 +++
 rtl/network_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/network_rx_pkg.sv
// rtl/network_rx_pkg.sv - shared types and EPA decode constants for the remote request responder
package network_rx_pkg;

  typedef enum logic [1:0] {
    e_remote_load  = 2'd0,
    e_remote_store = 2'd1,
    e_remote_amo   = 2'd2
  } bsg_manycore_packet_op_e;

  typedef struct packed {
    logic       is_byte;
    logic       is_hex;
    logic       is_unsigned;
    logic [1:0] part_sel;
  } bsg_manycore_load_info_s;

  // Region select bits counted down from the EPA MSB.
  localparam int epa_icache_offset_gp = 1;
  localparam int epa_csr_offset_gp    = 2;

  typedef enum logic [2:0] {
    e_csr_freeze      = 3'd0,
    e_csr_tgo_x       = 3'd1,
    e_csr_tgo_y       = 3'd2,
    e_csr_pc_init     = 3'd3,
    e_csr_dram_enable = 3'd4
  } csr_offset_e;

  typedef enum logic [1:0] {
    e_rx_dmem,
    e_rx_icache,
    e_rx_csr,
    e_rx_invalid
  } rx_target_e;

endpackage

// File: rtl/network_rx_load_packer.sv
// rtl/network_rx_load_packer.sv - byte/half select and sign/zero extension of a returning load word
module network_rx_load_packer
  import network_rx_pkg::*;
#(
  parameter int data_width_p = 32
) (
  input  logic [data_width_p-1:0]  data_i,
  input  bsg_manycore_load_info_s  load_info_i,
  output logic [data_width_p-1:0]  data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_ext;
  logic        half_ext;

  always_comb begin
    byte_sel = data_i[{load_info_i.part_sel, 3'b000} +: 8];
    half_sel = data_i[{load_info_i.part_sel[1], 4'b0000} +: 16];
    byte_ext = ~load_info_i.is_unsigned & byte_sel[7];
    half_ext = ~load_info_i.is_unsigned & half_sel[15];
    data_o   = data_i;
    if (load_info_i.is_byte) begin
      data_o = {{(data_width_p-8){byte_ext}}, byte_sel};
    end else if (load_info_i.is_hex) begin
      data_o = {{(data_width_p-16){half_ext}}, half_sel};
    end
  end

endmodule

// File: rtl/network_rx.sv
// rtl/network_rx.sv - tile-side responder decoding remote EPA requests into DMEM, icache and CSR accesses
module network_rx
  import network_rx_pkg::*;
#(
  parameter int data_width_p       = 32,
  parameter int addr_width_p       = 16,
  parameter int dmem_size_p        = 1024,
  parameter int icache_entries_p   = 1024,
  parameter int icache_tag_width_p = 12,
  parameter int x_subcord_width_p  = 4,
  parameter int y_subcord_width_p  = 3,
  localparam int dmem_addr_width_lp = $clog2(dmem_size_p),
  localparam int pc_width_lp        = icache_tag_width_p + $clog2(icache_entries_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          remote_req_v_i,
  input  logic [1:0]                    remote_req_op_i,
  input  logic [addr_width_p-1:0]       remote_req_addr_i,
  input  logic [data_width_p-1:0]       remote_req_data_i,
  input  logic [3:0]                    remote_req_mask_i,
  input  bsg_manycore_load_info_s       remote_req_load_info_i,
  output logic                          remote_yumi_o,
  output logic                          returning_v_o,
  output logic [data_width_p-1:0]       returning_data_o,
  output logic                          dmem_v_o,
  output logic                          dmem_w_o,
  output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
  output logic [data_width_p-1:0]       dmem_data_o,
  output logic [3:0]                    dmem_mask_o,
  input  logic                          dmem_yumi_i,
  input  logic [data_width_p-1:0]       dmem_data_i,
  output logic                          icache_v_o,
  output logic [pc_width_lp-1:0]        icache_pc_o,
  output logic [data_width_p-1:0]       icache_instr_o,
  input  logic                          icache_yumi_i,
  output logic                          freeze_o,
  output logic [x_subcord_width_p-1:0]  tgo_x_o,
  output logic [y_subcord_width_p-1:0]  tgo_y_o,
  output logic [pc_width_lp-1:0]        pc_init_o,
  output logic                          dram_enable_o,
  output logic                          invalid_access_o
);

  rx_target_e                   target;
  logic                         is_load, is_store;
  logic [addr_width_p-1:0]      icache_addr;
  logic [data_width_p-1:0]      csr_word, packer_in, packer_out;

  logic                         freeze_d, freeze_q;
  logic [x_subcord_width_p-1:0] tgo_x_d, tgo_x_q;
  logic [y_subcord_width_p-1:0] tgo_y_d, tgo_y_q;
  logic [pc_width_lp-1:0]       pc_init_d, pc_init_q;
  logic                         dram_enable_d, dram_enable_q;
  logic                         returning_v_d, returning_v_q;
  logic                         resp_dmem_load_d, resp_dmem_load_q;
  logic [data_width_p-1:0]      resp_data_d, resp_data_q;
  bsg_manycore_load_info_s      load_info_d, load_info_q;

  always_comb begin
    is_load  = remote_req_op_i == e_remote_load;
    is_store = remote_req_op_i == e_remote_store;
    if (remote_req_addr_i[addr_width_p-epa_icache_offset_gp]) begin
      target = is_store ? e_rx_icache : e_rx_invalid;
    end else if (remote_req_addr_i[addr_width_p-epa_csr_offset_gp]) begin
      target = ((is_load | is_store) && remote_req_addr_i[2:0] <= e_csr_dram_enable)
             ? e_rx_csr : e_rx_invalid;
    end else if (remote_req_addr_i < addr_width_p'(dmem_size_p)) begin
      target = (is_load | is_store) ? e_rx_dmem : e_rx_invalid;
    end else begin
      target = e_rx_invalid;
    end
  end

  // The region bit is not part of the fill address.
  always_comb begin
    icache_addr = remote_req_addr_i;
    icache_addr[addr_width_p-epa_icache_offset_gp] = 1'b0;
  end

  always_comb begin
    dmem_v_o         = remote_req_v_i & (target == e_rx_dmem);
    dmem_w_o         = dmem_v_o & is_store;
    dmem_addr_o      = dmem_v_o ? remote_req_addr_i[dmem_addr_width_lp-1:0] : '0;
    dmem_data_o      = dmem_v_o ? remote_req_data_i : '0;
    dmem_mask_o      = dmem_v_o ? remote_req_mask_i : '0;
    icache_v_o       = remote_req_v_i & (target == e_rx_icache);
    icache_pc_o      = icache_v_o ? pc_width_lp'(icache_addr) : '0;
    icache_instr_o   = icache_v_o ? remote_req_data_i : '0;
    invalid_access_o = remote_req_v_i & (target == e_rx_invalid) & ~reset_i;
    case (target)
      e_rx_dmem:   remote_yumi_o = remote_req_v_i & dmem_yumi_i;
      e_rx_icache: remote_yumi_o = remote_req_v_i & icache_yumi_i;
      default:     remote_yumi_o = remote_req_v_i;
    endcase
  end

  always_comb begin
    case (remote_req_addr_i[2:0])
      e_csr_freeze:      csr_word = data_width_p'(freeze_q);
      e_csr_tgo_x:       csr_word = data_width_p'(tgo_x_q);
      e_csr_tgo_y:       csr_word = data_width_p'(tgo_y_q);
      e_csr_pc_init:     csr_word = data_width_p'(pc_init_q);
      e_csr_dram_enable: csr_word = data_width_p'(dram_enable_q);
      default:           csr_word = '0;
    endcase
  end

  always_comb begin
    freeze_d      = freeze_q;
    tgo_x_d       = tgo_x_q;
    tgo_y_d       = tgo_y_q;
    pc_init_d     = pc_init_q;
    dram_enable_d = dram_enable_q;
    if (remote_req_v_i && target == e_rx_csr && is_store) begin
      case (remote_req_addr_i[2:0])
        e_csr_freeze:      freeze_d      = remote_req_data_i[0];
        e_csr_tgo_x:       tgo_x_d       = remote_req_data_i[x_subcord_width_p-1:0];
        e_csr_tgo_y:       tgo_y_d       = remote_req_data_i[y_subcord_width_p-1:0];
        e_csr_pc_init:     pc_init_d     = pc_width_lp'(remote_req_data_i);
        e_csr_dram_enable: dram_enable_d = remote_req_data_i[0];
        default:           ;
      endcase
    end
    returning_v_d    = remote_yumi_o;
    resp_dmem_load_d = remote_yumi_o & (target == e_rx_dmem) & is_load;
    resp_data_d      = (remote_yumi_o && target == e_rx_csr && is_load) ? csr_word : '0;
    load_info_d      = remote_req_load_info_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freeze_q         <= 1'b1;
      tgo_x_q          <= '0;
      tgo_y_q          <= '0;
      pc_init_q        <= '0;
      dram_enable_q    <= 1'b0;
      returning_v_q    <= 1'b0;
      resp_dmem_load_q <= 1'b0;
      resp_data_q      <= '0;
      load_info_q      <= '0;
    end else begin
      freeze_q         <= freeze_d;
      tgo_x_q          <= tgo_x_d;
      tgo_y_q          <= tgo_y_d;
      pc_init_q        <= pc_init_d;
      dram_enable_q    <= dram_enable_d;
      returning_v_q    <= returning_v_d;
      resp_dmem_load_q <= resp_dmem_load_d;
      resp_data_q      <= resp_data_d;
      load_info_q      <= load_info_d;
    end
  end

  // DMEM read data arrives the cycle after the grant, so it bypasses the response register.
  assign packer_in = resp_dmem_load_q ? dmem_data_i : resp_data_q;

  network_rx_load_packer #(.data_width_p(data_width_p)) load_packer (
    .data_i      (packer_in),
    .load_info_i (load_info_q),
    .data_o      (packer_out)
  );

  assign returning_v_o    = returning_v_q;
  assign returning_data_o = returning_v_q ? packer_out : '0;
  assign freeze_o         = freeze_q;
  assign tgo_x_o          = tgo_x_q;
  assign tgo_y_o          = tgo_y_q;
  assign pc_init_o        = pc_init_q;
  assign dram_enable_o    = dram_enable_q;

endmodule
